// File: rtl/shift_feed_pkg.sv
// Shared accelerator definitions: feeder FSM states and default geometry constants.
package shift_feed_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_IN_WIDTH   = 8;
    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_DRAIN = 2'd2
    } feed_state_t;

endpackage

// File: rtl/shift_feed_cnt.sv
// Common up-counter with synchronous clear; clear wins over increment.
module shift_feed_cnt
    import shift_feed_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/shift_feed.sv
// Packs RATIO narrow input beats into one wide output word per handshake,
// with a separate assembly register so the next word fills while one is held.
module shift_feed
    import shift_feed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           Rst,
    input  logic                           CfgVld,
    output logic                           CfgRdy,
    input  logic [CNT_WIDTH-1:0]           CfgNumWord,
    input  logic [IN_WIDTH*DATA_WIDTH-1:0] din,
    input  logic                           din_vld,
    output logic                           din_rdy,
    output logic [WIDTH*DATA_WIDTH-1:0]    dout,
    output logic                           dout_vld,
    output logic                           dout_last,
    input  logic                           dout_rdy,
    output logic                           busy
);

    localparam int unsigned RATIO     = WIDTH / IN_WIDTH;
    localparam int unsigned BEAT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned BEAT_BITS = IN_WIDTH * DATA_WIDTH;
    localparam int unsigned WORD_BITS = WIDTH * DATA_WIDTH;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RATIO - 1);

    feed_state_t            state_q;
    feed_state_t            state_d;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [CNT_WIDTH-1:0]   word_cnt;
    logic [CNT_WIDTH-1:0]   num_word;
    logic [WORD_BITS-1:0]   asm_reg;
    logic [WORD_BITS-1:0]   word_next;
    logic                   cfg_fire;
    logic                   beat_final;
    logic                   din_fire;
    logic                   word_load;
    logic                   dout_pop;
    logic                   last_word;

    assign CfgRdy     = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign cfg_fire   = CfgVld & CfgRdy & ~Rst;
    assign beat_final = (beat_cnt == BEAT_LAST);
    // Final beat may only enter when the output register is free or being popped.
    assign din_rdy    = (state_q == ST_PACK) & (~beat_final | ~dout_vld | dout_rdy);
    assign din_fire   = din_vld & din_rdy;
    assign word_load  = din_fire & beat_final & ~Rst;
    assign dout_pop   = dout_vld & dout_rdy;
    assign last_word  = (word_cnt == num_word - CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (cfg_fire && CfgNumWord != '0) state_d = ST_PACK;
                ST_PACK:  if (word_load && last_word)       state_d = ST_DRAIN;
                ST_DRAIN: if (dout_pop)                     state_d = ST_IDLE;
                default:                                    state_d = ST_IDLE;
            endcase
        end
    end

    shift_feed_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (Rst | cfg_fire),
        .inc   (word_load),
        .count (word_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            num_word <= '0;
        end else if (Rst) begin
            beat_cnt <= '0;
        end else if (cfg_fire) begin
            beat_cnt <= '0;
            num_word <= CfgNumWord;
        end else if (din_fire) begin
            beat_cnt <= beat_final ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

    // The final beat bypasses the assembly register straight into the output word.
    always_ff @(posedge clk) begin
        if (din_fire && !beat_final) begin
            asm_reg[beat_cnt*BEAT_BITS +: BEAT_BITS] <= din;
        end
    end

    always_comb begin
        word_next = asm_reg;
        word_next[WORD_BITS-1 -: BEAT_BITS] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
        end else if (Rst) begin
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
        end else if (word_load) begin
            dout      <= word_next;
            dout_vld  <= 1'b1;
            dout_last <= last_word;
        end else if (dout_pop) begin
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_feed.sv
// Bench for shift_feed: table of frame scenarios run against an element-queue scoreboard.
module tb_shift_feed;

    localparam int DW    = 8;
    localparam int INW   = 8;
    localparam int W     = 32;
    localparam int CW    = 16;
    localparam int RATIO = W / INW;

    typedef struct {
        int num;
        int vld_pct;
        int rdy_pct;
        int seq;
        int stall;
        int exp_cyc;
        int exp_words;
        int exp_lasts;
    } frame_vec_t;

    logic                clk;
    logic                rst_n;
    logic                Rst;
    logic                CfgVld;
    logic                CfgRdy;
    logic [CW-1:0]       CfgNumWord;
    logic [INW*DW-1:0]   din;
    logic                din_vld;
    logic                din_rdy;
    logic [W*DW-1:0]     dout;
    logic                dout_vld;
    logic                dout_last;
    logic                dout_rdy;
    logic                busy;

    int checks;
    int errors;
    logic [DW-1:0] elem_q[$];
    frame_vec_t vecs[8];

    shift_feed #(
        .DATA_WIDTH (DW),
        .IN_WIDTH   (INW),
        .WIDTH      (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rst        (Rst),
        .CfgVld     (CfgVld),
        .CfgRdy     (CfgRdy),
        .CfgNumWord (CfgNumWord),
        .din        (din),
        .din_vld    (din_vld),
        .din_rdy    (din_rdy),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .dout_last  (dout_last),
        .dout_rdy   (dout_rdy),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_frame(input frame_vec_t v, output int words, output int lasts, output int cyc);
        logic [W*DW-1:0] exp_word;
        logic [W*DW-1:0] prev_dout;
        logic            prev_last;
        logic            hold;
        logic            exp_vld;
        logic            exp_rdy;
        logic            stall_armed;
        int              stall_left;
        int              beats;
        int              budget;
        int              busy_exp;
        int              done;
        elem_q.delete();
        words = 0; lasts = 0; cyc = 0; beats = 0; done = 0;
        hold = 1'b0; exp_vld = 1'b0; prev_dout = '0; prev_last = 1'b0;
        stall_armed = (v.stall > 0);
        stall_left = 0;
        busy_exp = (v.num != 0) ? 1 : 0;
        budget = v.num * RATIO * 50 + 50;

        @(negedge clk);
        CfgVld = 1'b1; CfgNumWord = CW'(v.num); din_vld = 1'b0; dout_rdy = 1'b0;
        #1;
        chk("cfg_rdy_start", CfgRdy, 1);

        for (int n = 0; n < budget && done == 0; n++) begin
            @(negedge clk);
            CfgVld = 1'b0;
            din_vld = ($urandom_range(99) < v.vld_pct);
            for (int j = 0; j < INW; j++)
                din[j*DW +: DW] = (v.seq != 0) ? DW'(beats * INW + j) : DW'($urandom);
            if (stall_left > 0) begin
                dout_rdy = 1'b0;
                stall_left--;
            end else begin
                dout_rdy = stall_armed ? 1'b0 : ($urandom_range(99) < v.rdy_pct);
            end
            #1;
            chk("busy", busy, busy_exp != 0);
            chk("cfg_rdy", CfgRdy, busy_exp == 0);
            if (busy_exp == 0) begin
                done = 1;
            end else begin
                cyc++;
                exp_rdy = (beats < v.num * RATIO) &&
                          ((beats % RATIO) != RATIO - 1 || !dout_vld || dout_rdy);
                chk("din_rdy", din_rdy, exp_rdy);
                if (exp_vld) chk("dout_vld_latency", dout_vld, 1);
                if (hold) begin
                    chk("hold_vld", dout_vld, 1);
                    chk("hold_dout", dout, prev_dout);
                    chk("hold_last", dout_last, prev_last);
                end
                exp_vld = 1'b0;
                if (dout_vld && dout_rdy) begin
                    chk("queue_underflow", elem_q.size() >= W, 1);
                    if (elem_q.size() >= W) begin
                        for (int i = 0; i < W; i++) exp_word[i*DW +: DW] = elem_q.pop_front();
                        chk("dout_word", dout, exp_word);
                    end
                    chk("dout_last", dout_last, words == v.num - 1);
                    if (dout_last) lasts++;
                    words++;
                    if (words >= v.num) busy_exp = 0;
                end
                if (din_vld && din_rdy) begin
                    for (int j = 0; j < INW; j++) elem_q.push_back(din[j*DW +: DW]);
                    beats++;
                    if (beats % RATIO == 0) exp_vld = 1'b1;
                end
                hold = dout_vld && !dout_rdy;
                prev_dout = dout;
                prev_last = dout_last;
                if (stall_armed && dout_vld) begin
                    stall_armed = 1'b0;
                    stall_left = v.stall;
                end
            end
        end
        chk("frame_done", done, 1);

        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            din_vld = 1'b1; dout_rdy = 1'b1;
            #1;
            chk("excess_din_rdy", din_rdy, 0);
            chk("idle_dout_vld", dout_vld, 0);
        end
        din_vld = 1'b0; dout_rdy = 1'b0;
        chk("leftover_elems", elem_q.size(), 0);
    endtask

    initial begin
        int words;
        int lasts;
        int cyc;
        int beats;
        frame_vec_t one;
        checks = 0; errors = 0;
        rst_n = 1'b0; Rst = 1'b0; CfgVld = 1'b0; CfgNumWord = '0;
        din = '0; din_vld = 1'b0; dout_rdy = 1'b0;

        vecs[0] = '{3,    100, 100, 1, 0,  13, 3,    1};
        vecs[1] = '{2,    100, 100, 1, 10, 0,  2,    1};
        vecs[2] = '{0,    100, 100, 0, 0,  0,  0,    0};
        vecs[3] = '{1,    100, 100, 0, 0,  5,  1,    1};
        vecs[4] = '{5,    50,  50,  0, 0,  0,  5,    1};
        vecs[5] = '{17,   30,  95,  0, 0,  0,  17,   1};
        vecs[6] = '{12,   95,  25,  0, 0,  0,  12,   1};
        vecs[7] = '{1000, 70,  60,  0, 0,  0,  1000, 1};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din_rdy", din_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_cfg_rdy", CfgRdy, 1);

        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k], words, lasts, cyc);
            chk("frame_words", words, vecs[k].exp_words);
            chk("frame_lasts", lasts, vecs[k].exp_lasts);
            if (vecs[k].exp_cyc != 0) chk("frame_cycles", cyc, vecs[k].exp_cyc);
        end

        // Synchronous Rst while word 0 is held and beat 2 of word 1 is being offered.
        @(negedge clk);
        CfgVld = 1'b1; CfgNumWord = CW'(3); din_vld = 1'b0; dout_rdy = 1'b0;
        beats = 0;
        for (int n = 0; n < 40 && beats < 6; n++) begin
            @(negedge clk);
            CfgVld = 1'b0; din_vld = 1'b1; dout_rdy = 1'b0;
            din = {INW{DW'(n)}};
            #1;
            if (din_vld && din_rdy) beats++;
        end
        chk("rst_seq_beats", beats, 6);
        @(negedge clk);
        Rst = 1'b1; din_vld = 1'b1; dout_rdy = 1'b1;
        #1;
        chk("rst_seq_pre_vld", dout_vld, 1);
        chk("rst_seq_pre_busy", busy, 1);
        @(negedge clk);
        Rst = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
        #1;
        chk("rst_seq_busy", busy, 0);
        chk("rst_seq_vld", dout_vld, 0);
        chk("rst_seq_last", dout_last, 0);
        chk("rst_seq_din_rdy", din_rdy, 0);
        chk("rst_seq_cfg_rdy", CfgRdy, 1);
        one = '{1, 100, 100, 1, 0, 5, 1, 1};
        run_frame(one, words, lasts, cyc);
        chk("rst_seq_words", words, 1);
        chk("rst_seq_lasts", lasts, 1);
        chk("rst_seq_cycles", cyc, 5);

        // Asynchronous rst_n between clock edges while a word is held.
        @(negedge clk);
        CfgVld = 1'b1; CfgNumWord = CW'(2); din_vld = 1'b0; dout_rdy = 1'b0;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            CfgVld = 1'b0; din_vld = 1'b1; dout_rdy = 1'b0;
            din = {INW{8'hA5}};
        end
        #1;
        chk("arst_pre_vld", dout_vld, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", dout_vld, 0);
        chk("arst_last", dout_last, 0);
        chk("arst_dout", dout, 0);
        chk("arst_busy", busy, 0);
        chk("arst_din_rdy", din_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1; din_vld = 1'b0;
        #1;
        chk("arst_cfg_rdy", CfgRdy, 1);
        chk("arst_busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
